// File: rtl/const_bank_pkg.sv
// Shared parameters and FSM state type for the constant bank writer.
package const_bank_pkg;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;
endpackage

// File: rtl/const_bank_writer_if.sv
// Load-request and write-stream handshake between a producer and the bank writer.
interface const_bank_writer_if #(parameter int DATA_W = const_bank_pkg::DATA_W);
  logic              start;
  logic              load_all;
  logic              half_sel;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic              busy;
  logic              done;

  modport master (output start, load_all, half_sel, wr_data, wr_valid,
                  input  wr_ready, busy, done);
  modport slave  (input  start, load_all, half_sel, wr_data, wr_valid,
                  output wr_ready, busy, done);
endinterface

// File: rtl/const_bank_regs.sv
// Constant bank storage: one write port, reads one half (LANES words) at a time.
module const_bank_regs #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int LANES  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic [$clog2(DEPTH)-1:0]       waddr,
  input  logic [DATA_W-1:0]              wdata,
  input  logic                           rd_pos,
  output logic [LANES-1:0][DATA_W-1:0]   rdata
);
  logic [DEPTH-1:0][DATA_W-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (rst)     mem_q <= '0;
    else if (we) mem_q[waddr] <= wdata;
  end

  // Purely combinational read: a half being loaded shows old and new words mixed.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign rdata[l] = rd_pos ? mem_q[LANES+l] : mem_q[l];
  end
endmodule

// File: rtl/const_bank_writer.sv
// Loads constant words into one half or the whole bank from a valid/ready stream.
module const_bank_writer #(
  parameter int DATA_W = const_bank_pkg::DATA_W,
  parameter int DEPTH  = const_bank_pkg::DEPTH,
  parameter int LANES  = const_bank_pkg::LANES
) (
  input  logic               clk,
  input  logic               rst,
  const_bank_writer_if.slave bus,
  input  logic               rd_pos,
  output logic [DATA_W-1:0]  out1,
  output logic [DATA_W-1:0]  out2,
  output logic [DATA_W-1:0]  out3,
  output logic [DATA_W-1:0]  out4
);
  import const_bank_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_e                       state_q, state_d;
  logic [AW-1:0]                base_q, base_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [CW-1:0]                tgt_q, tgt_d;
  logic                         we;
  logic [AW-1:0]                waddr;
  logic [LANES-1:0][DATA_W-1:0] rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    we      = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        base_d  = (!bus.load_all && bus.half_sel) ? AW'(LANES) : '0;
        tgt_d   = bus.load_all ? CW'(DEPTH) : CW'(LANES);
        cnt_d   = '0;
        state_d = LOAD;
      end
      LOAD: if (bus.wr_valid) begin
        we    = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == tgt_q - CW'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign waddr = base_q + cnt_q[AW-1:0];

  const_bank_regs #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES)) u_regs (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (bus.wr_data),
    .rd_pos (rd_pos),
    .rdata  (rdata)
  );

  // Outputs are forced quiet while reset is held, even before the first edge.
  assign bus.wr_ready = (state_q == LOAD) && !rst;
  assign bus.busy     = (state_q == LOAD) && !rst;
  assign bus.done     = (state_q == DONE) && !rst;

  assign out1 = rst ? '0 : rdata[0];
  assign out2 = rst ? '0 : rdata[1];
  assign out3 = rst ? '0 : rdata[2];
  assign out4 = rst ? '0 : rdata[3];
endmodule

// File: doc/const_bank_writer.md
CONST_BANK_WRITER -- requirements
Module: const_bank_writer

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, giving the constant word width.
REQ-002 The module SHALL have parameter DEPTH, default 8, giving the number of bank entries.
REQ-003 The module SHALL have parameter LANES, default 4, giving the words per read half.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port start, input, 1 bit: request to begin a load.
REQ-007 The module SHALL have port load_all, input, 1 bit: sampled with start; 1 loads all 8 entries, 0 loads one half.
REQ-008 The module SHALL have port half_sel, input, 1 bit: sampled with start; selects half 0 (entries 0-3) or half 1 (entries 4-7).
REQ-009 The module SHALL have port wr_data, input, DATA_W bits: the constant word.
REQ-010 The module SHALL have port wr_valid, input, 1 bit: wr_data is valid.
REQ-011 The module SHALL have port wr_ready, output, 1 bit: the block accepts a word this cycle.
REQ-012 The module SHALL have port rd_pos, input, 1 bit: read half select, 0 gives entries 0-3 and 1 gives entries 4-7.
REQ-013 The module SHALL have ports out1, out2, out3, out4, output, DATA_W bits each: lanes 0-3 of the selected half.
REQ-014 The module SHALL have port busy, output, 1 bit: high in LOAD.
REQ-015 The module SHALL have port done, output, 1 bit: one-cycle pulse when a load completes.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, LOAD and DONE.
REQ-017 In IDLE, when start=1, the block SHALL latch base (0 if load_all=1, else half_sel*4), latch target count (8 if load_all=1, else 4), clear the count and enter LOAD.
REQ-018 In IDLE and DONE, wr_ready SHALL be 0, so a wr_valid arriving in the same cycle as start SHALL NOT write.
REQ-019 In LOAD, wr_ready SHALL be 1, and each cycle with wr_valid=1 SHALL write wr_data to entry base+count and increment count.
REQ-020 A LOAD cycle with wr_valid=0 SHALL change nothing.
REQ-021 The handshake that writes the last word (count = target-1) SHALL move the FSM to DONE.
REQ-022 DONE SHALL assert done for exactly one cycle and then return to IDLE unconditionally.
REQ-023 start SHALL be ignored in LOAD and DONE, and there SHALL be no queued request.
REQ-024 The read outputs SHALL be combinational from the bank and rd_pos: outN = entry[rd_pos*4 + N-1].
REQ-025 A written word SHALL appear on the read outputs in the cycle after its handshake.
REQ-026 A read of the half being loaded SHALL return a mix of new and old words, with no stalling or masking.
REQ-027 The entry index SHALL be 3 bits, and base+count SHALL never exceed 7 (no wrap-around).
REQ-028 Entries outside the loaded range SHALL hold their values.

Reset
REQ-029 When rst=1 at a clock edge, the block SHALL clear all 8 entries to 0, set the state to IDLE, and clear count, base and target.
REQ-030 While rst=1, the outputs SHALL be: wr_ready=0, busy=0, done=0, out1-out4=0.
REQ-031 Reset SHALL take priority over start and over any handshake in the same cycle.
REQ-032 Reset during LOAD SHALL abort the load, discard any partial data and produce no done pulse.

Structure
REQ-033 The package const_bank_pkg SHALL hold DATA_W, DEPTH, LANES and the state enum type (IDLE, LOAD, DONE).
REQ-034 A single sub-module const_bank_regs SHALL contain the 8-entry storage, the write port (we, waddr, wdata) and the rd_pos read mux.
REQ-035 The FSM, count and base logic SHALL reside in const_bank_writer.

Verification
REQ-036 The bench SHALL check: reset, then rd_pos=0 and rd_pos=1 -> all outputs are 0.
REQ-037 The bench SHALL check: start with half_sel=1, load_all=0, then words 0xA0..0xA3 sent back-to-back -> rd_pos=1 reads A0,A1,A2,A3, rd_pos=0 still reads 0, and done pulses once, 1 cycle after the 4th handshake.
REQ-038 The bench SHALL check: start with load_all=1 and words 0x10..0x17 with wr_valid gaps on alternate cycles -> half 0 reads 10-13, half 1 reads 14-17, and busy is high throughout.
REQ-039 The bench SHALL check: wr_valid=1 with 0xFF in the same cycle as start, then 0x01..0x04 -> 0xFF is not written and half 0 reads 01-04.
REQ-040 The bench SHALL check: start pulsed again mid-load, then 2 more words -> it is ignored, and the load completes after exactly 4 words in total.
REQ-041 The bench SHALL check: rst asserted after 2 of 4 words -> no done pulse, all entries are 0, and the FSM is in IDLE with wr_ready=0 the next cycle.
